local_packet_injector: RTL and testbench
========================================

# local_packet_injector

Traffic source for one mesh node's local input port, the mirror of the node's collector sink. It periodically builds 32-bit packets tagged with a 10-bit packet ID, its own 6-bit sender ID and a pseudo-random destination ID. Packets queue in a small FIFO and are offered to the router's local port over the Req/Gnt/Full handshake. It counts sent and dropped packets for end-of-run statistics.

## Interface
Parameters:
- `routerID`: 6'b000_000. Node coordinate {x[2:0], y[2:0]}; used as the sender ID and for self-destination exclusion.
- `ModuleID`: 6'b000_000. PE identifier; informational only.
- `dataWidth`: 32. Packet width.
- `dim`: 4. Mesh dimension; coordinates are 0..dim-1.
- `INJ_PERIOD`: 8. Cycles between generation attempts; must be ≥ 1.
- `MAX_PACKETS`: 1023. Generation stops after this many accepted packets.
- `QUEUE_DEPTH`: 4. FIFO entries; must be a power of 2.
- `LFSR_SEED`: 16'hACE1. Destination LFSR reset value; must be nonzero.

Ports:
- `clk` input 1: Clock, rising edge.
- `reset` input 1: Asynchronous, active-high reset.
- `enable` input 1: Generation enable. Draining of the FIFO continues when low.
- `PacketOut` output dataWidth: Packet offered to the router local port.
- `ReqDnStr` output 1: Request to the router local port.
- `GntDnStr` input 1: Grant from the router local port.
- `DnStrFull` input 1: Router local buffer full.
- `sent_count` output 16: Packets granted.
- `drop_count` output 16: Generation attempts lost to a full FIFO.
- `done` output 1: High when MAX_PACKETS have been generated, the FIFO is empty and the FSM is IDLE.

## Operation
- Packet format:
  - [31:22] zero.
  - [21:16] destination ID.
  - [15:6] PacketID.
  - [5:0] routerID.
- Period counter:
  - Counts 0..INJ_PERIOD-1, then wraps to 0. It counts only while `enable` is high.
  - A generation attempt happens on the wrap cycle if `gen_count` < MAX_PACKETS.
- Destination:
  - The 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per attempt.
  - x = lfsr[1:0] mod dim, y = lfsr[3:2] mod dim.
  - If {x,y} equals routerID, x becomes (x+1) mod dim.
- Attempt outcome:
  - If the FIFO is not full (evaluated on pre-pop occupancy): push the packet, then PacketID and `gen_count` increment.
  - Otherwise: `drop_count` increments; PacketID and `gen_count` are unchanged.
- PacketID is 10 bits and wraps 1023→0. `sent_count` and `drop_count` saturate at 16'hFFFF.
- Send FSM states:
  - IDLE: if the FIFO is non-empty and !DnStrFull, go to REQ. `ReqDnStr` is 0.
  - REQ: `ReqDnStr`=1 and `PacketOut`=FIFO head, both held stable. When `GntDnStr`=1, pop the FIFO, increment `sent_count` and go to RELEASE. `DnStrFull` rising while in REQ does not withdraw the request.
  - RELEASE: `ReqDnStr`=0 for exactly one cycle, then go to IDLE.
- A grant seen outside REQ is ignored.

## Timing
- Reset values:
  - `ReqDnStr` 0, `PacketOut` 0, counters 0, `done` 0.
  - FSM IDLE, FIFO empty, PacketID 0, period counter 0, LFSR = LFSR_SEED.
- Reset mid-handshake: the request drops asynchronously and any queued packets are discarded.
- First attempt occurs INJ_PERIOD cycles after `enable` is first sampled high.
- A packet pushed at edge N is at the FIFO head at N+1. The FSM enters REQ at N+2 if the link is free, so `ReqDnStr` is visible after edge N+2.
- Minimum spacing between packets is 3 cycles: REQ(grant) → RELEASE → IDLE → REQ. This is compatible with a sink that grants one cycle after request and clears the grant the following cycle.
- `PacketOut` changes only on entry to REQ. Otherwise it holds its last value.

## Structure
- Shared package `noc_pkg` holds:
  - Field positions (PID_MSB=15, PID_LSB=6, SID_MSB=5, DST_MSB=21, DST_LSB=16).
  - The send-FSM state encoding.
  - The ID width constant (6).
- Sub-module `injector_fifo`:
  - Parameterised synchronous FIFO (dataWidth, QUEUE_DEPTH) with push/pop/full/empty.
  - Pointers carry an extra wrap bit.
- The top level contains the period counter, LFSR, packet assembly, send FSM and statistics.

## Test plan
- Reset/idle: reset high then low with `enable`=0 for 50 cycles → `ReqDnStr` stays 0, `PacketOut`=0, all counts 0.
- Single packet, routerID=6'b001_010, INJ_PERIOD=8, always-grant sink (grant one cycle after request) → first request 10 cycles after `enable`; PacketOut[15:6]=0 and [5:0]=6'b001_010; `sent_count`=1.
- Backpressure: hold `DnStrFull`=1 and `GntDnStr`=0 for 100 cycles with INJ_PERIOD=4, QUEUE_DEPTH=4 → 4 packets queued, `drop_count`=21, no request. Release → PacketIDs 0,1,2,3 delivered in order.
- Self-exclusion: force an LFSR seed whose first destination equals routerID → emitted destination has x incremented mod dim and never equals routerID over 1000 packets.
- Limit/done: MAX_PACKETS=5 with a free link → exactly 5 packets (IDs 0..4), then `done`=1 and no further requests.
- Reset while in REQ: assert `reset` mid-request → `ReqDnStr` falls before the next clock edge; after release, PacketID restarts at 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the mesh-node traffic blocks: packet field
// positions, ID width, send-FSM state encoding and a coordinate helper.
package noc_pkg;

  localparam int ID_W    = 6;
  localparam int PID_MSB = 15;
  localparam int PID_LSB = 6;
  localparam int PID_W   = PID_MSB - PID_LSB + 1;
  localparam int SID_MSB = 5;
  localparam int SID_LSB = 0;
  localparam int DST_MSB = 21;
  localparam int DST_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } send_state_t;

  // Reduce a small coordinate value into 0..d-1.
  function automatic logic [2:0] coord_mod(input logic [2:0] v, input int d);
    int r;
    r = int'(v) % d;
    return r[2:0];
  endfunction

endpackage

// File: rtl/injector_fifo.sv
// Synchronous FIFO for queued packets. Pointers carry an extra wrap bit so
// full and empty are told apart without a separate counter. The head is
// read through a register; o_head_valid is delayed to match that register,
// so a word pushed at edge N is presented (and flagged valid) after N+1.
// DEPTH must be a power of two and at least 2.
module injector_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_head_valid,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_head;
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_head_valid;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  assign o_head       = r_head;
  assign o_head_valid = r_head_valid;

  // Storage write and registered head read; left without reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
    r_head <= r_mem[r_rd_ptr[AW-1:0]];
  end

  // Pointer update and head-valid flag aligned with the registered read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_head_valid <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_head_valid <= !o_empty;
    end
  end

endmodule

// File: rtl/local_packet_injector.sv
// Traffic source for a mesh node's local input port. Periodically builds
// packets {dest, PacketID, routerID}, queues them, and offers them to the
// router over Req/Gnt/Full with a one-cycle release gap between packets.
module local_packet_injector
  import noc_pkg::*;
#(
  parameter logic [5:0]  routerID    = 6'b000_000,
  parameter logic [5:0]  ModuleID    = 6'b000_000,
  parameter int          dataWidth   = 32,
  parameter int          dim         = 4,
  parameter int          INJ_PERIOD  = 8,
  parameter int          MAX_PACKETS = 1023,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic [dataWidth-1:0] PacketOut,
  output logic                 ReqDnStr,
  input  logic                 GntDnStr,
  input  logic                 DnStrFull,
  output logic [15:0]          sent_count,
  output logic [15:0]          drop_count,
  output logic                 done
);

  localparam logic [15:0] PERIOD_LAST = 16'(INJ_PERIOD - 1);
  localparam logic [15:0] GEN_LIMIT   = 16'(MAX_PACKETS);

  // ModuleID is informational only; parked on a deliberately unused wire.
  logic [5:0] w_unused_module_id;
  assign w_unused_module_id = ModuleID;

  logic [15:0]          r_period_cnt;
  logic [15:0]          r_lfsr;
  logic [PID_W-1:0]     r_pid;
  logic [15:0]          r_gen_count;
  logic [15:0]          r_sent;
  logic [15:0]          r_drop;
  logic                 r_done;
  logic [dataWidth-1:0] r_packet_out;
  send_state_t          r_state;
  send_state_t          w_state_next;

  logic                 w_wrap;
  logic                 w_attempt;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic                 w_load_out;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_head_valid;
  logic [dataWidth-1:0] w_head;
  logic                 w_lfsr_fb;
  logic [2:0]           w_x_raw;
  logic [2:0]           w_x;
  logic [2:0]           w_y;
  logic [ID_W-1:0]      w_dst;
  logic [dataWidth-1:0] w_packet;

  // ---------------------------------------------------------------------
  // Generation timing
  // ---------------------------------------------------------------------
  assign w_wrap    = enable && (r_period_cnt == PERIOD_LAST);
  assign w_attempt = w_wrap && (r_gen_count < GEN_LIMIT);
  // Full is judged on occupancy before any same-cycle pop.
  assign w_push    = w_attempt && !w_fifo_full;
  assign w_drop    = w_attempt && w_fifo_full;

  // Period counter: advances only while enabled, wraps after INJ_PERIOD counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period_cnt <= '0;
    end else if (enable) begin
      r_period_cnt <= w_wrap ? 16'd0 : r_period_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Destination selection
  // ---------------------------------------------------------------------
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Destination LFSR steps once per attempt, whether or not the packet fits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_attempt) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_x_raw = coord_mod({1'b0, r_lfsr[1:0]}, dim);
  assign w_y     = coord_mod({1'b0, r_lfsr[3:2]}, dim);
  // Never address ourselves: nudge x along the row when the draw hits home.
  assign w_x     = ({w_x_raw, w_y} == routerID) ? coord_mod(w_x_raw + 3'd1, dim)
                                                : w_x_raw;
  assign w_dst   = {w_x, w_y};

  // Packet assembly: unused upper bits stay zero.
  always_comb begin
    w_packet                   = '0;
    w_packet[DST_MSB:DST_LSB]  = w_dst;
    w_packet[PID_MSB:PID_LSB]  = r_pid;
    w_packet[SID_MSB:SID_LSB]  = routerID;
  end

  // PacketID and generated count move only when a packet is actually queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pid       <= '0;
      r_gen_count <= '0;
    end else if (w_push) begin
      r_pid       <= r_pid + 1'b1;
      r_gen_count <= r_gen_count + 16'd1;
    end
  end

  injector_fifo #(
    .DATA_W (dataWidth),
    .DEPTH  (QUEUE_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_data       (w_packet),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_head_valid (w_head_valid),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Send FSM
  // ---------------------------------------------------------------------
  // State register; async reset drops the request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; grants outside REQ are ignored.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load_out   = 1'b0;
    ReqDnStr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_head_valid && !DnStrFull) begin
          w_state_next = ST_REQ;
          w_load_out   = 1'b1;
        end
      end
      ST_REQ: begin
        ReqDnStr = 1'b1;
        if (GntDnStr) begin
          w_pop        = 1'b1;
          w_state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output packet register: captured on entry to REQ, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_packet_out <= '0;
    end else if (w_load_out) begin
      r_packet_out <= w_head;
    end
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
  // Saturating sent/drop counters and registered completion flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sent <= '0;
      r_drop <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_pop && (r_sent != 16'hFFFF)) begin
        r_sent <= r_sent + 16'd1;
      end
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
      r_done <= (r_gen_count == GEN_LIMIT) && w_fifo_empty && (r_state == ST_IDLE);
    end
  end

  assign PacketOut  = r_packet_out;
  assign sent_count = r_sent;
  assign drop_count = r_drop;
  assign done       = r_done;

endmodule

// File: tb/tb_local_packet_injector.sv
// Self-checking bench for local_packet_injector: a transaction-level model
// predicts queued packets and drops, a monitor checks every granted packet.
module tb_local_packet_injector;

  localparam logic [5:0]  RID    = 6'b001_010;
  localparam int          DIM    = 4;
  localparam int          PERIOD = 4;
  localparam int          DEPTH  = 4;
  localparam int          MAXP   = 30;
  // Low nibble 4'b1001 -> first draw x=1,y=2 which is RID itself.
  localparam logic [15:0] SEED   = 16'hACE9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        GntDnStr = 1'b0;
  logic        DnStrFull = 1'b0;
  logic [31:0] PacketOut;
  logic        ReqDnStr;
  logic [15:0] sent_count;
  logic [15:0] drop_count;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic sink_en = 1'b0;
  logic sink_rand = 1'b0;

  always #5 clk = ~clk;

  local_packet_injector #(
    .routerID    (RID),
    .ModuleID    (6'd7),
    .dataWidth   (32),
    .dim         (DIM),
    .INJ_PERIOD  (PERIOD),
    .MAX_PACKETS (MAXP),
    .QUEUE_DEPTH (DEPTH),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .PacketOut  (PacketOut),
    .ReqDnStr   (ReqDnStr),
    .GntDnStr   (GntDnStr),
    .DnStrFull  (DnStrFull),
    .sent_count (sent_count),
    .drop_count (drop_count),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  function automatic logic [31:0] make_packet(input logic [15:0] l, input int pid);
    int x, y, dst;
    x = (int'(l) % 4) % DIM;
    y = ((int'(l) / 4) % 4) % DIM;
    if (x * 8 + y == int'(RID)) x = (x + 1) % DIM;
    dst = x * 8 + y;
    return 32'(dst * 65536 + pid * 64 + int'(RID));
  endfunction

  logic [31:0] exp_q[$];
  int          m_cnt, m_pid, m_gen, m_occ, m_drop;
  logic [15:0] m_lfsr;

  // Predicts what the coming rising edge does; inputs are stable at negedge.
  always @(negedge clk) begin
    if (reset) begin
      m_cnt = 0; m_pid = 0; m_gen = 0; m_occ = 0; m_drop = 0;
      m_lfsr = SEED;
      exp_q.delete();
    end else begin
      if (enable) begin
        if (m_cnt == PERIOD - 1) begin
          m_cnt = 0;
          if (m_gen < MAXP) begin
            if (m_occ < DEPTH) begin
              exp_q.push_back(make_packet(m_lfsr, m_pid));
              m_pid = (m_pid + 1) % 1024;
              m_gen++;
              m_occ++;
            end else begin
              m_drop++;
            end
            m_lfsr = lfsr_step(m_lfsr);
          end
        end else begin
          m_cnt++;
        end
      end
      if (ReqDnStr && GntDnStr) m_occ--;
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] prev_pkt;
  logic        prev_req = 1'b0;
  logic        prev_hs = 1'b0;
  logic        prev2_hs = 1'b0;

  always @(negedge clk) begin
    logic        hs;
    logic [31:0] exp_pkt;
    if (reset) begin
      prev_req = 1'b0; prev_hs = 1'b0; prev2_hs = 1'b0;
      prev_pkt = PacketOut;
    end else begin
      hs = ReqDnStr && GntDnStr;
      if (!(ReqDnStr && !prev_req)) check("pkt_hold", PacketOut, prev_pkt);
      if (prev_req && !prev_hs) check("req_hold", 32'(ReqDnStr), 32'd1);
      if (prev_hs || prev2_hs) check("req_gap", 32'(ReqDnStr), 32'd0);
      if (hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pkt_unexpected actual=%0h required=none", PacketOut);
        end else begin
          exp_pkt = exp_q.pop_front();
          check("pkt_data", PacketOut, exp_pkt);
          check("pkt_not_self", 32'(PacketOut[21:16] == RID), 32'd0);
          check("pkt_upper_zero", 32'(PacketOut[31:22]), 32'd0);
          $display("tb: packet pid=%0d dst=%02h sid=%02h", PacketOut[15:6], PacketOut[21:16], PacketOut[5:0]);
        end
      end
      prev2_hs = prev_hs;
      prev_hs  = hs;
      prev_req = ReqDnStr;
      prev_pkt = PacketOut;
    end
  end

  // ---------------- sink ----------------
  initial begin
    int wait_cnt;
    int dly;
    wait_cnt = 0;
    dly = 0;
    forever begin
      @(posedge clk); #1;
      if (reset || !sink_en) begin
        GntDnStr = 1'b0;
        wait_cnt = 0;
      end else if (GntDnStr) begin
        GntDnStr = 1'b0;
        wait_cnt = 0;
        dly = sink_rand ? int'($urandom_range(0, 3)) : 0;
      end else if (ReqDnStr) begin
        if (wait_cnt >= dly) GntDnStr = 1'b1;
        else wait_cnt++;
      end else if (sink_rand && ($urandom_range(0, 7) == 0)) begin
        GntDnStr = 1'b1;  // stray grant while not requesting
      end
    end
  end

  task automatic do_reset();
    enable = 1'b0;
    DnStrFull = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   lat;
    int   cyc;
    logic seen_req;

    // Reset and idle with enable low.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    seen_req = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      seen_req |= ReqDnStr;
    end
    check("idle_req", 32'(seen_req), 32'd0);
    check("idle_pkt", PacketOut, 32'd0);
    check("idle_sent", 32'(sent_count), 32'd0);
    check("idle_drop", 32'(drop_count), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Single packet, always-grant sink.
    do_reset();
    sink_en = 1'b1;
    sink_rand = 1'b0;
    enable = 1'b1;
    lat = 0;
    while (!ReqDnStr && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_req_latency", 32'(lat), 32'(PERIOD + 2));
    check("first_pid", 32'(PacketOut[15:6]), 32'd0);
    check("first_sid", 32'(PacketOut[5:0]), 32'(RID));
    check("first_dst_excl", 32'(PacketOut[21:16]), 32'(6'b010_010));
    lat = 0;
    while (sent_count == 16'd0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_sent", 32'(sent_count), 32'd1);
    enable = 1'b0;

    // Backpressure: link full, no grants, 100 enabled cycles.
    do_reset();
    sink_en = 1'b0;
    DnStrFull = 1'b1;
    enable = 1'b1;
    seen_req = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      seen_req |= ReqDnStr;
    end
    enable = 1'b0;
    check("bp_no_req", 32'(seen_req), 32'd0);
    check("bp_drop", 32'(drop_count), 32'd21);
    check("bp_sent_zero", 32'(sent_count), 32'd0);
    DnStrFull = 1'b0;
    sink_en = 1'b1;
    lat = 0;
    while (sent_count < 16'd4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (10) @(posedge clk);
    #1;
    check("bp_sent", 32'(sent_count), 32'd4);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a request is outstanding.
    do_reset();
    sink_en = 1'b0;
    enable = 1'b1;
    lat = 0;
    while (!ReqDnStr && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rst_req_up", 32'(ReqDnStr), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_req_async", 32'(ReqDnStr), 32'd0);
    check("rst_pkt_clear", PacketOut, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    sink_en = 1'b1;
    lat = 0;
    while (!ReqDnStr && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rst_pid_restart", 32'(PacketOut[15:6]), 32'd0);
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Randomised run to the packet limit.
    do_reset();
    sink_en = 1'b1;
    sink_rand = 1'b1;
    cyc = 0;
    while (!done && cyc < 4000) begin
      enable = ($urandom_range(0, 9) != 0);
      DnStrFull = ($urandom_range(0, 4) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("done_reached", 32'(done), 32'd1);
    check("limit_sent", 32'(sent_count), 32'(MAXP));
    check("limit_drop", 32'(drop_count), 32'(m_drop));
    check("limit_drained", 32'(exp_q.size()), 32'd0);
    DnStrFull = 1'b0;
    enable = 1'b1;
    seen_req = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      seen_req |= ReqDnStr;
    end
    check("no_req_after_done", 32'(seen_req), 32'd0);
    check("done_held", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
